// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - cycle/event counter with halt-confirm and watchdog-timeout FSM
module run_monitor #(
    parameter int CNT_W        = 32,
    parameter int PC_W         = 16,
    parameter int NUM_EVT      = 4,
    parameter int CYCLES_LIMIT = 100000,
    parameter int HALT_CONFIRM = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     hlt,
    input  logic [PC_W-1:0]          pc,
    input  logic [NUM_EVT-1:0]       evt,
    output logic [CNT_W-1:0]         cycles,
    output logic [NUM_EVT*CNT_W-1:0] evt_cnt,
    output logic [PC_W-1:0]          halt_pc,
    output logic                     done,
    output logic                     timeout,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        CONFIRM = 2'b01,
        HALTED  = 2'b10,
        TIMEOUT = 2'b11
    } state_t;

    // A limit wider than the counter can never be reached, so the watchdog is disabled.
    localparam bit              LIMIT_FITS  = ((CYCLES_LIMIT >> CNT_W) == 0);
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(CYCLES_LIMIT);
    localparam logic [8:0]      CONFIRM_LEN = 9'(HALT_CONFIRM);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cycles_q, cycles_d;
    logic [NUM_EVT*CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic [PC_W-1:0]            halt_pc_q, halt_pc_d;
    logic [7:0]                 run_len_q, run_len_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;
    logic                       active;
    logic [8:0]                 run_len_inc;

    assign active      = (state_q == RUN) || (state_q == CONFIRM);
    assign run_len_inc = {1'b0, run_len_q} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cycles_q  <= '0;
            evt_cnt_q <= '0;
            halt_pc_q <= '0;
            run_len_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            evt_cnt_q <= evt_cnt_d;
            halt_pc_q <= halt_pc_d;
            run_len_q <= run_len_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        evt_cnt_d = evt_cnt_q;
        halt_pc_d = halt_pc_q;
        run_len_d = run_len_q;

        if (active) begin
            cycles_d = cycles_q + 1'b1;
            for (int i = 0; i < NUM_EVT; i++) begin
                if (evt[i] && (evt_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    evt_cnt_d[i*CNT_W +: CNT_W] = evt_cnt_q[i*CNT_W +: CNT_W] + 1'b1;
                end
            end

            if (hlt) begin
                run_len_d = run_len_inc[7:0];
                if (run_len_q == 8'd0) begin
                    halt_pc_d = pc;
                end
            end else begin
                run_len_d = '0;
            end

            // Halt qualification outranks the watchdog when both land on one edge.
            if (hlt && (run_len_inc >= CONFIRM_LEN)) begin
                state_d = HALTED;
            end else if (LIMIT_FITS && (cycles_d == LIMIT)) begin
                state_d = TIMEOUT;
            end else if (hlt) begin
                state_d = CONFIRM;
            end else begin
                state_d = RUN;
            end
        end

        if (clr) begin
            state_d   = RUN;
            cycles_d  = '0;
            evt_cnt_d = '0;
            halt_pc_d = '0;
            run_len_d = '0;
        end

        done_d    = (state_d == HALTED);
        timeout_d = (state_d == TIMEOUT);
    end

    assign state   = state_q;
    assign cycles  = cycles_q;
    assign evt_cnt = evt_cnt_q;
    assign halt_pc = halt_pc_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule
